dht22_reader: RTL
=================

// Module: dht22_reader
// PURPOSE
//  Parametrised single-wire DHT22/AM2302 sensor reader. Replaces the fixed 1 s free-running
//  poller with triggered or periodic reads, per-phase timeouts, MSB-first data capture and
//  registered humidity/temperature outputs. Sits between the Pmod pin tristate (top level) and
//  the seven-segment/display logic; the top level drives the pin as dht_oe ? 1'b0 : 1'bz.
// PARAMETERS
//  CLK_HZ         100_000_000  clock frequency; all timings are derived from it
//  START_LOW_US   1000         host start-pulse low time (us)
//  BIT_THRESH_US  50           high-time threshold: > threshold -> '1', else '0'
//  TIMEOUT_US     200          max wait in any sensor-driven phase before abort
//  AUTO_PERIOD_MS 2000         auto-read period measured from end of last read; 0 = start only
//  SYNC_STAGES    2            input synchroniser depth (>= 2)
// PORTS
//  CLK100MHZ     in   1   system clock
//  CPU_RESETN    in   1   asynchronous active-low reset
//  start         in   1   1-cycle read request; ignored while busy=1
//  dht_in        in   1   raw pin level (asynchronous)
//  dht_oe        out  1   1 = pull bus low; 0 = release (pull-up makes it high)
//  busy          out  1   high from accepted start until the final outcome pulse
//  valid         out  1   1-cycle pulse: new data with good checksum
//  checksum_err  out  1   1-cycle pulse: 40 bits received, checksum mismatch
//  timeout_err   out  1   1-cycle pulse: phase timeout, read aborted
//  humidity      out  16  raw RH x10, bytes [39:24] of last good frame
//  temperature   out  16  raw T x10 sign-magnitude (bit15 = negative), bytes [23:8]
//  raw_data      out  40  last received frame, good or bad
// BEHAVIOUR
//  - Reset (async, CPU_RESETN=0): state=IDLE, all counters 0, dht_oe=0, busy=0, valid=0,
//    checksum_err=0, timeout_err=0, humidity=0, temperature=0, raw_data=0, sync regs=1.
//  - Constants: START_CYC=CLK_HZ/1e6*START_LOW_US; THR_CYC, TO_CYC likewise (us);
//    PER_CYC=CLK_HZ/1e3*AUTO_PERIOD_MS. Defaults: 100000, 5000, 20000, 200_000_000.
//  - dht_s = last stage of SYNC_STAGES flop chain on dht_in; the FSM uses dht_s only.
//  - FSM (single 32-bit phase counter cnt, cleared on every state change):
//    IDLE:     start=1 or (AUTO_PERIOD_MS!=0 and period counter reaches PER_CYC) -> START_LOW.
//    START_LOW: dht_oe=1 for exactly START_CYC cycles -> RELEASE (dht_oe=0).
//    RELEASE:  wait dht_s=0 (sensor ack low)          -> ACK_LOW.
//    ACK_LOW:  wait dht_s=1                           -> ACK_HIGH.
//    ACK_HIGH: wait dht_s=0; clear bit index to 0      -> BIT_LOW.
//    BIT_LOW:  wait dht_s=1                           -> BIT_HIGH.
//    BIT_HIGH: count while dht_s=1; on dht_s=0: bit = (cnt > THR_CYC); shift in MSB-first
//              (shreg <= {shreg[38:0],bit}); index+1; index==40 -> CHECK else BIT_LOW.
//    CHECK:    1 cycle; sum = (b4+b3+b2+b1) mod 256 compared to b0; raw_data<=frame;
//              match -> humidity/temperature updated, valid=1; else checksum_err=1 -> IDLE.
//  - Timeout: in RELEASE..BIT_HIGH, cnt reaching TO_CYC -> timeout_err=1 for 1 cycle, IDLE;
//    outputs humidity/temperature/raw_data unchanged.
//  - busy=1 in every state except IDLE; it falls in the same cycle the outcome pulse is driven.
//  - Exactly one of valid/checksum_err/timeout_err pulses per accepted read; none otherwise.
//  - Period counter resets on leaving each read; start in IDLE also resets it.
//    start and period expiry in the same cycle -> one read only.
//  - start while busy: dropped, not queued.
//  - dht_oe is 1 only in START_LOW; 0 in all other states, after timeout, and after reset.
//  - Reset mid-read: bus released immediately (dht_oe=0 asynchronously), no pulse emitted.
// TESTING
//  1 Sensor model sends 0x02_8C_01_5F_EE (RH 65.2%, T 35.1C), start pulse -> dht_oe low
//    exactly 100000 cycles, then valid=1 once, humidity=16'h028C, temperature=16'h015F.
//  2 Frame 0x02_8C_80_65_73 -> valid, temperature=16'h8065 (-10.1C), bit15=1.
//  3 Frame with checksum byte 0xEF instead of 0xEE -> checksum_err=1 once, humidity/
//    temperature keep previous values, raw_data=40'h028C015FEF.
//  4 Sensor never acks (dht_in held 1) -> timeout_err=1 exactly 20000 cycles after release,
//    busy falls, dht_oe stays 0; sensor stops mid-bit 17 -> timeout_err, no valid.
//  5 High times of 4999 and 5001 cycles -> decoded '0' and '1' respectively (boundary).
//  6 Second start during a read -> ignored, one outcome pulse; CPU_RESETN low mid-frame ->
//    dht_oe=0, busy=0 immediately, no pulse; AUTO_PERIOD_MS=1 -> reads repeat every
//    100000 cycles after each completion without start.

Source files
------------

// File: rtl/dht22_reader.sv
// DHT22/AM2302 single-wire reader: triggered or periodic reads, per-phase
// timeouts, MSB-first capture and checksum-qualified registered outputs.
module dht22_reader #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned START_LOW_US   = 1000,
  parameter int unsigned BIT_THRESH_US  = 50,
  parameter int unsigned TIMEOUT_US     = 200,
  parameter int unsigned AUTO_PERIOD_MS = 2000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        start,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic        busy,
  output logic        valid,
  output logic        checksum_err,
  output logic        timeout_err,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic [39:0] raw_data
);

  localparam int unsigned START_CYC = CLK_HZ / 1_000_000 * START_LOW_US;
  localparam int unsigned THR_CYC   = CLK_HZ / 1_000_000 * BIT_THRESH_US;
  localparam int unsigned TO_CYC    = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned PER_CYC   = CLK_HZ / 1_000 * AUTO_PERIOD_MS;

  localparam logic [31:0] START_M1 = 32'(START_CYC - 1);
  localparam logic [31:0] TO_M1    = 32'(TO_CYC - 1);
  localparam logic [31:0] PER_M1   = 32'(PER_CYC - 1);
  localparam logic [31:0] THR_C    = 32'(THR_CYC);
  localparam bit          AUTO_EN  = (AUTO_PERIOD_MS != 0);

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    RELEASE,
    ACK_LOW,
    ACK_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        dht_s;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] per_q, per_d;
  logic [5:0]  idx_q, idx_d;
  logic [39:0] shreg_q, shreg_d;
  logic        valid_q, valid_d;
  logic        cerr_q, cerr_d;
  logic        terr_q, terr_d;
  logic [15:0] hum_q, hum_d;
  logic [15:0] tmp_q, tmp_d;
  logic [39:0] raw_q, raw_d;

  logic        per_hit;
  logic        to_hit;
  logic        last_bit;
  logic        waiting;
  logic        shift_en;
  logic        sum_ok;
  logic [7:0]  sum8;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dht_in};
    end
  end

  assign dht_s    = sync_q[SYNC_STAGES-1];
  assign per_hit  = AUTO_EN && (per_q == PER_M1);
  assign to_hit   = (cnt_q == TO_M1);
  assign last_bit = (idx_q == 6'd39);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start || per_hit) state_d = START_LOW;
      end
      START_LOW: begin
        if (cnt_q == START_M1) state_d = RELEASE;
      end
      RELEASE: begin
        if (!dht_s)      state_d = ACK_LOW;
        else if (to_hit) state_d = IDLE;
      end
      ACK_LOW: begin
        if (dht_s)       state_d = ACK_HIGH;
        else if (to_hit) state_d = IDLE;
      end
      ACK_HIGH: begin
        if (!dht_s)      state_d = BIT_LOW;
        else if (to_hit) state_d = IDLE;
      end
      BIT_LOW: begin
        if (dht_s)       state_d = BIT_HIGH;
        else if (to_hit) state_d = IDLE;
      end
      BIT_HIGH: begin
        if (!dht_s)      state_d = last_bit ? CHECK : BIT_LOW;
        else if (to_hit) state_d = IDLE;
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    dht_oe   = (state_q == START_LOW);
    busy     = (state_q != IDLE);
    waiting  = state_q inside {RELEASE, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH};
    shift_en = (state_q == BIT_HIGH) && !dht_s;
    sum8     = shreg_q[39:32] + shreg_q[31:24] + shreg_q[23:16] + shreg_q[15:8];
    sum_ok   = (sum8 == shreg_q[7:0]);
  end

  always_comb begin
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 32'd1;
    per_d = (AUTO_EN && state_q == IDLE && state_d == IDLE) ? per_q + 32'd1 : '0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (state_q == ACK_HIGH) idx_d = '0;
    // cnt trails the high time by one cycle, so >= means high time > threshold
    if (shift_en) begin
      idx_d   = idx_q + 6'd1;
      shreg_d = {shreg_q[38:0], cnt_q >= THR_C};
    end
    valid_d = (state_q == CHECK) && sum_ok;
    cerr_d  = (state_q == CHECK) && !sum_ok;
    terr_d  = waiting && (state_d == IDLE);
    raw_d   = (state_q == CHECK) ? shreg_q : raw_q;
    hum_d   = valid_d ? shreg_q[39:24] : hum_q;
    tmp_d   = valid_d ? shreg_q[23:8] : tmp_q;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt_q   <= '0;
      per_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      cerr_q  <= 1'b0;
      terr_q  <= 1'b0;
      hum_q   <= '0;
      tmp_q   <= '0;
      raw_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      cerr_q  <= cerr_d;
      terr_q  <= terr_d;
      hum_q   <= hum_d;
      tmp_q   <= tmp_d;
      raw_q   <= raw_d;
    end
  end

  assign valid        = valid_q;
  assign checksum_err = cerr_q;
  assign timeout_err  = terr_q;
  assign humidity     = hum_q;
  assign temperature  = tmp_q;
  assign raw_data     = raw_q;

endmodule
